// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-4 Booth signed multiplier, one operand pair in flight (optional BOOTH_EARLY_EXIT_EN)
module booth_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy,
  output logic [2:0]         booth_code,
  output logic               pp_op,
  output logic [1:0]         pp_sel
);
  localparam int N  = WIDTH / 2;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   areg_q, areg_d;
  logic [WIDTH:0]     mreg_q, mreg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, out_p_q, out_p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] a_ext, mag, pp;
  logic               last;
  // Booth recode of the current group, partial product, and next-state sequencing
  always_comb begin
    state_d = state_q;
    areg_d = areg_q;
    mreg_d = mreg_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    out_p_d = out_p_q;
    last = 1'b0;
    booth_code = (state_q == RUN) ? mreg_q[2:0] : 3'b000;
    pp_sel = (booth_code == 3'b011 || booth_code == 3'b100) ? 2'b10 :
             (booth_code == 3'b000 || booth_code == 3'b111) ? 2'b00 : 2'b01;
    pp_op = booth_code[2] && booth_code[1:0] != 2'b11;
    a_ext = {{WIDTH{areg_q[WIDTH-1]}}, areg_q};
    mag = (pp_sel == 2'b10) ? a_ext << 1 : (pp_sel == 2'b01) ? a_ext : '0;
    pp = pp_op ? -mag : mag;
    if (clr) begin
      state_d = IDLE;
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      areg_d = in_a;
      mreg_d = {in_b, 1'b0};
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      acc_d = acc_q + (pp << {cnt_q, 1'b0});
      mreg_d = {{2{mreg_q[WIDTH]}}, mreg_q[WIDTH:2]};
      cnt_d = cnt_q + CW'(1);
`ifdef BOOTH_EARLY_EXIT_EN
      last = cnt_q == CW'(N - 1) || &mreg_d || ~|mreg_d;
`else
      last = cnt_q == CW'(N - 1);
`endif
      if (last) begin
        state_d = DONE;
        out_p_d = acc_d;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      areg_q <= '0;
      mreg_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out_p_q <= '0;
    end else begin
      state_q <= state_d;
      areg_q <= areg_d;
      mreg_q <= mreg_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_p_q <= out_p_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q == RUN;
  assign out_valid = state_q == DONE;
  assign out_p = out_p_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// tb_booth_mul_seq: directed checks of the Booth multiplier sequencer
module tb_booth_mul_seq;
  logic        clk = 0, rst = 0, clr = 0, in_valid = 0, out_ready = 1;
  logic [15:0] in_a = 0, in_b = 0;
  logic        in_ready, out_valid, busy, pp_op;
  logic [31:0] out_p;
  logic [2:0]  booth_code;
  logic [1:0]  pp_sel;
  int checks = 0, passed = 0;

  booth_mul_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy), .booth_code(booth_code), .pp_op(pp_op), .pp_sel(pp_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " recode"}, 64'({booth_code, pp_op, pp_sel}), 64'd0);
  endtask

  // accept one pair, wait for the product, check latency and value, then take it
  task automatic do_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int lat);
    int n;
    in_a = a;
    in_b = b;
    in_valid = 1;
    out_ready = 1;
    tick();
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    if (lat > 0) chk({tag, " latency"}, 64'(n), 64'(lat));
    else chk({tag, " latency<=8"}, 64'(n >= 1 && n <= 8), 64'd1);
    chk({tag, " product"}, 64'(out_p), 64'(exp));
    tick();
    chk({tag, " back to idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] held;
    int          lat_fix;
`ifdef BOOTH_EARLY_EXIT_EN
    lat_fix = 0;
`else
    lat_fix = 8;
`endif
    #12;
    rst = 1;
    tick();
    idle_outs("reset");
    chk("reset out_p", 64'(out_p), 64'd0);

    // first RUN cycle of 3*5: group {0,1,0} selects +A
    in_a = 16'd3;
    in_b = 16'd5;
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("run busy", 64'(busy), 64'd1);
    chk("run in_ready", 64'(in_ready), 64'd0);
    chk("run first group", 64'({booth_code, pp_op, pp_sel}), 64'({3'b010, 1'b0, 2'b01}));
    in_a = 16'hFFFF;
    in_b = 16'hFFFF;
    tick(12);
    chk("3x5 product", 64'(out_p), 64'h0000000F);
    tick();

    do_mul("3x5", 16'd3, 16'd5, 32'h0000000F, lat_fix);
    do_mul("min*min", 16'h8000, 16'h8000, 32'h40000000, lat_fix);
    do_mul("min*max", 16'h8000, 16'h7FFF, 32'hC0008000, lat_fix);
    do_mul("-1x1", 16'hFFFF, 16'd1, 32'hFFFFFFFF, lat_fix);
    do_mul("max*-1", 16'h7FFF, 16'hFFFF, 32'hFFFF8001, lat_fix);

    // back-pressure with a pending operand
    in_a = 16'd100;
    in_b = 16'd100;
    in_valid = 1;
    tick();
    in_a = 16'd2;
    in_b = 16'd2;
    out_ready = 0;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp out_p", 64'(out_p), 64'd10000);
      chk("bp in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1;
    tick();
    chk("bp handoff idle", 64'(in_ready), 64'd1);
    chk("bp handoff no accept", 64'(busy), 64'd0);
    in_valid = 0;
    tick();
    chk("bp pending dropped", 64'(busy | out_valid), 64'd0);

    // synchronous abort at RUN cycle 4
    held = out_p;
    in_a = 16'd11;
    in_b = 16'd13;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick(3);
    clr = 1;
    tick();
    clr = 0;
    idle_outs("clr");
    begin
      int seen = 0;
      for (int i = 0; i < 10; i++) begin
        seen |= int'(out_valid);
        tick();
      end
      chk("clr no out_valid", 64'(seen), 64'd0);
    end
    chk("clr out_p retained", 64'(out_p), 64'(held));
    do_mul("7x2", 16'd7, 16'd2, 32'h0000000E, lat_fix == 0 ? 2 : 8);

    // asynchronous reset mid-RUN
    in_a = 16'd50;
    in_b = 16'd60;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick(2);
    rst = 0;
    #1;
    idle_outs("async rst");
    chk("async rst out_p", 64'(out_p), 64'd0);
    #2;
    rst = 1;
    tick();
    do_mul("3x5 after rst", 16'd3, 16'd5, 32'h0000000F, lat_fix);

`ifdef BOOTH_EARLY_EXIT_EN
    do_mul("ee 9x-1", 16'd9, 16'hFFFF, 32'hFFFFFFF7, 1);
    do_mul("ee 9x0", 16'd9, 16'd0, 32'h00000000, 1);
    for (int i = 0; i < 1000; i++) begin
`else
    for (int i = 0; i < 100; i++) begin
`endif
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_mul("random", ra, rb, 32'($signed(ra) * $signed(rb)), lat_fix);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
